// File: rtl/reg_file_pkg.sv
// Shared configuration for the architectural register file.
//   DEFAULT_ROB_SIZE_BIT : width of a reorder-buffer id
//   ROB_SIZE             : number of ROB entries
//   REG_NUM              : number of architectural registers
//   REG_ID_W             : register index width (fixed at 5)
package reg_file_pkg;

    localparam int unsigned DEFAULT_ROB_SIZE_BIT = 5;
    localparam int unsigned ROB_SIZE             = 1 << DEFAULT_ROB_SIZE_BIT;
    localparam int unsigned REG_NUM              = 32;
    localparam int unsigned REG_ID_W             = 5;

    typedef logic [REG_ID_W-1:0] reg_id_t;

endpackage

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags.
// Holds 32 x 32-bit values plus a busy flag and the ROB id of the youngest
// in-flight producer for every register. ROB commits write values, decoder
// issue writes rename tags, and two combinational query ports return either
// the value or the pending ROB dependency, with same-cycle commit bypass.
//
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (state frozen when low)
//   rob_clear                         : flush, drops every rename tag
//   is_update_val / update_val_id / update_val_dep / update_val : commit
//   is_update_dep / update_dep_id / update_dep                  : rename
//   qryN_id -> qryN_val / qryN_has_dep / qryN_dep (N = 1, 2)    : queries
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned ROB_SIZE_BIT = DEFAULT_ROB_SIZE_BIT
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    rob_clear,

    input  logic                    is_update_val,
    input  logic [REG_ID_W-1:0]     update_val_id,
    input  logic [ROB_SIZE_BIT-1:0] update_val_dep,
    input  logic [31:0]             update_val,

    input  logic                    is_update_dep,
    input  logic [REG_ID_W-1:0]     update_dep_id,
    input  logic [ROB_SIZE_BIT-1:0] update_dep,

    input  logic [REG_ID_W-1:0]     qry1_id,
    output logic [31:0]             qry1_val,
    output logic                    qry1_has_dep,
    output logic [ROB_SIZE_BIT-1:0] qry1_dep,

    input  logic [REG_ID_W-1:0]     qry2_id,
    output logic [31:0]             qry2_val,
    output logic                    qry2_has_dep,
    output logic [ROB_SIZE_BIT-1:0] qry2_dep
);

    logic [31:0]             val_q [REG_NUM];
    logic [31:0]             val_d [REG_NUM];
    logic [ROB_SIZE_BIT-1:0] dep_q [REG_NUM];
    logic [ROB_SIZE_BIT-1:0] dep_d [REG_NUM];
    logic [REG_NUM-1:0]      busy_q;
    logic [REG_NUM-1:0]      busy_d;

    always_comb begin
        val_d  = val_q;
        dep_d  = dep_q;
        busy_d = busy_q;
        if (rob_clear) begin
            // Commit/rename inputs are meaningless while the ROB clears.
            busy_d = '0;
        end else begin
            if (is_update_val && (update_val_id != '0)) begin
                val_d[update_val_id] = update_val;
                // Only the youngest producer may release the register.
                if (busy_q[update_val_id] && (dep_q[update_val_id] == update_val_dep)) begin
                    busy_d[update_val_id] = 1'b0;
                end
            end
            // Applied after the commit so a same-register rename wins.
            if (is_update_dep && (update_dep_id != '0)) begin
                busy_d[update_dep_id] = 1'b1;
                dep_d[update_dep_id]  = update_dep;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                dep_q[i] <= '0;
            end
            busy_q <= '0;
        end else if (rdy_in) begin
            val_q  <= val_d;
            dep_q  <= dep_d;
            busy_q <= busy_d;
        end
    end

    // Query ports: identical logic, selected through small arrays.
    reg_id_t                 qry_id      [2];
    logic [31:0]             qry_val_w   [2];
    logic                    qry_has_w   [2];
    logic [ROB_SIZE_BIT-1:0] qry_dep_w   [2];

    assign qry_id[0] = qry1_id;
    assign qry_id[1] = qry2_id;

    for (genvar p = 0; p < 2; p++) begin : g_qry
        logic hit;
        // Same-cycle commit of the youngest producer forwards its value.
        // The same-cycle rename is deliberately not forwarded.
        assign hit = is_update_val && !rob_clear
                     && (update_val_id == qry_id[p]) && (qry_id[p] != '0)
                     && busy_q[qry_id[p]] && (dep_q[qry_id[p]] == update_val_dep);
        assign qry_val_w[p] = hit ? update_val : val_q[qry_id[p]];
        assign qry_has_w[p] = busy_q[qry_id[p]] && !hit;
        assign qry_dep_w[p] = dep_q[qry_id[p]];
    end

    assign qry1_val     = qry_val_w[0];
    assign qry1_has_dep = qry_has_w[0];
    assign qry1_dep     = qry_dep_w[0];
    assign qry2_val     = qry_val_w[1];
    assign qry2_has_dep = qry_has_w[1];
    assign qry2_dep     = qry_dep_w[1];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus a randomized run
// compared against a behavioural model of the register/tag state.
module tb_reg_file;

    localparam int RB = 5;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          rob_clear;
    logic          is_update_val;
    logic [4:0]    update_val_id;
    logic [RB-1:0] update_val_dep;
    logic [31:0]   update_val;
    logic          is_update_dep;
    logic [4:0]    update_dep_id;
    logic [RB-1:0] update_dep;
    logic [4:0]    qry1_id;
    logic [31:0]   qry1_val;
    logic          qry1_has_dep;
    logic [RB-1:0] qry1_dep;
    logic [4:0]    qry2_id;
    logic [31:0]   qry2_val;
    logic          qry2_has_dep;
    logic [RB-1:0] qry2_dep;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    logic [31:0]   m_val  [32];
    logic          m_busy [32];
    logic [RB-1:0] m_dep  [32];

    reg_file #(.ROB_SIZE_BIT(RB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .is_update_val(is_update_val), .update_val_id(update_val_id),
        .update_val_dep(update_val_dep), .update_val(update_val),
        .is_update_dep(is_update_dep), .update_dep_id(update_dep_id),
        .update_dep(update_dep),
        .qry1_id(qry1_id), .qry1_val(qry1_val), .qry1_has_dep(qry1_has_dep),
        .qry1_dep(qry1_dep),
        .qry2_id(qry2_id), .qry2_val(qry2_val), .qry2_has_dep(qry2_has_dep),
        .qry2_dep(qry2_dep)
    );

    always #5 clk_in = ~clk_in;

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0; m_busy[i] = 1'b0; m_dep[i] = '0;
        end
    endfunction

    // Expected query answer from the current model and current inputs.
    function automatic void exp_q(input logic [4:0] id, output logic [31:0] v,
                                  output logic h, output logic [RB-1:0] d);
        v = m_val[id]; h = m_busy[id]; d = m_dep[id];
        if (id != 0 && is_update_val && !rob_clear && update_val_id == id
            && m_busy[id] && m_dep[id] == update_val_dep) begin
            v = update_val; h = 1'b0;
        end
    endfunction

    task automatic idle_inputs();
        rdy_in = 1'b1; rob_clear = 1'b0;
        is_update_val = 1'b0; update_val_id = '0; update_val_dep = '0; update_val = '0;
        is_update_dep = 1'b0; update_dep_id = '0; update_dep = '0;
    endtask

    // Clock edge: advance the model with the inputs present at the edge,
    // then return inputs to idle slightly after the edge.
    task automatic tick();
        @(posedge clk_in);
        if (rdy_in) begin
            if (rob_clear) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else begin
                if (is_update_val && update_val_id != 0) begin
                    m_val[update_val_id] = update_val;
                    if (m_busy[update_val_id] && m_dep[update_val_id] == update_val_dep)
                        m_busy[update_val_id] = 1'b0;
                end
                if (is_update_dep && update_dep_id != 0) begin
                    m_busy[update_dep_id] = 1'b1;
                    m_dep[update_dep_id]  = update_dep;
                end
            end
        end
        #1;
        idle_inputs();
        #1;
    endtask

    task automatic test_reset();
        // Scramble some state first, then pulse reset between edges.
        for (int i = 1; i < 8; i++) begin
            is_update_val = 1'b1; update_val_id = 5'(i); update_val = $urandom;
            is_update_dep = 1'b1; update_dep_id = 5'(i); update_dep = RB'(i);
            tick();
        end
        @(negedge clk_in);
        #2 rst_in = 1'b1;
        model_clear();
        qry1_id = 5'd5; qry2_id = 5'd0;
        #1;
        n_total++;
        if (qry1_val !== 32'h0 || qry1_has_dep !== 1'b0 || qry1_dep !== '0)
            $display("FAIL reset_q1: got val=%h has=%b dep=%0d, want 0/0/0",
                     qry1_val, qry1_has_dep, qry1_dep);
        else n_pass++;
        n_total++;
        if (qry2_val !== 32'h0 || qry2_has_dep !== 1'b0 || qry2_dep !== '0)
            $display("FAIL reset_q2: got val=%h has=%b dep=%0d, want 0/0/0",
                     qry2_val, qry2_has_dep, qry2_dep);
        else n_pass++;
        #1 rst_in = 1'b0;
        for (int i = 0; i < 32; i++) begin
            qry1_id = 5'(i);
            #1;
            n_total++;
            if (qry1_val !== 32'h0 || qry1_has_dep !== 1'b0)
                $display("FAIL reset_all x%0d: got val=%h has=%b, want 0/0",
                         i, qry1_val, qry1_has_dep);
            else n_pass++;
        end
    endtask

    task automatic test_rename_commit();
        is_update_dep = 1'b1; update_dep_id = 5'd5; update_dep = 5'd3;
        tick();
        qry1_id = 5'd5; #1;
        n_total++;
        if (qry1_has_dep !== 1'b1 || qry1_dep !== 5'd3)
            $display("FAIL rename: got has=%b dep=%0d, want 1/3", qry1_has_dep, qry1_dep);
        else n_pass++;
        is_update_val = 1'b1; update_val_id = 5'd5; update_val_dep = 5'd3;
        update_val = 32'h1234; #1;
        n_total++;
        if (qry1_has_dep !== 1'b0 || qry1_val !== 32'h1234)
            $display("FAIL commit_bypass: got has=%b val=%h, want 0/1234",
                     qry1_has_dep, qry1_val);
        else n_pass++;
        tick();
        n_total++;
        if (qry1_has_dep !== 1'b0 || qry1_val !== 32'h1234)
            $display("FAIL commit_stored: got has=%b val=%h, want 0/1234",
                     qry1_has_dep, qry1_val);
        else n_pass++;
    endtask

    task automatic test_stale_commit();
        is_update_dep = 1'b1; update_dep_id = 5'd5; update_dep = 5'd3; tick();
        is_update_dep = 1'b1; update_dep_id = 5'd5; update_dep = 5'd7; tick();
        is_update_val = 1'b1; update_val_id = 5'd5; update_val_dep = 5'd3;
        update_val = 32'hAA; qry1_id = 5'd5; #1;
        n_total++;
        if (qry1_has_dep !== 1'b1 || qry1_dep !== 5'd7 || qry1_val !== 32'h1234)
            $display("FAIL stale_nobypass: got has=%b dep=%0d val=%h, want 1/7/1234",
                     qry1_has_dep, qry1_dep, qry1_val);
        else n_pass++;
        tick();
        n_total++;
        if (qry1_has_dep !== 1'b1 || qry1_dep !== 5'd7 || qry1_val !== 32'hAA)
            $display("FAIL stale_stored: got has=%b dep=%0d val=%h, want 1/7/aa",
                     qry1_has_dep, qry1_dep, qry1_val);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        is_update_dep = 1'b1; update_dep_id = 5'd6; update_dep = 5'd2; tick();
        is_update_val = 1'b1; update_val_id = 5'd6; update_val_dep = 5'd2;
        update_val = 32'h55;
        is_update_dep = 1'b1; update_dep_id = 5'd6; update_dep = 5'd9;
        qry2_id = 5'd6; #1;
        n_total++;
        if (qry2_has_dep !== 1'b0 || qry2_val !== 32'h55)
            $display("FAIL same_bypass: got has=%b val=%h, want 0/55", qry2_has_dep, qry2_val);
        else n_pass++;
        tick();
        n_total++;
        if (qry2_has_dep !== 1'b1 || qry2_dep !== 5'd9 || qry2_val !== 32'h55)
            $display("FAIL same_stored: got has=%b dep=%0d val=%h, want 1/9/55",
                     qry2_has_dep, qry2_dep, qry2_val);
        else n_pass++;
    endtask

    task automatic test_x0();
        is_update_val = 1'b1; update_val_id = 5'd0; update_val_dep = 5'd0;
        update_val = 32'hFFFF;
        is_update_dep = 1'b1; update_dep_id = 5'd0; update_dep = 5'd4;
        qry1_id = 5'd0; #1;
        n_total++;
        if (qry1_val !== 32'h0 || qry1_has_dep !== 1'b0 || qry1_dep !== '0)
            $display("FAIL x0_same: got val=%h has=%b dep=%0d, want 0/0/0",
                     qry1_val, qry1_has_dep, qry1_dep);
        else n_pass++;
        tick();
        n_total++;
        if (qry1_val !== 32'h0 || qry1_has_dep !== 1'b0 || qry1_dep !== '0)
            $display("FAIL x0_after: got val=%h has=%b dep=%0d, want 0/0/0",
                     qry1_val, qry1_has_dep, qry1_dep);
        else n_pass++;
    endtask

    task automatic test_flush_and_stall();
        logic [31:0] old3;
        old3 = m_val[3];
        is_update_dep = 1'b1; update_dep_id = 5'd3; update_dep = 5'd10; tick();
        is_update_dep = 1'b1; update_dep_id = 5'd4; update_dep = 5'd11; tick();
        rob_clear = 1'b1;
        is_update_val = 1'b1; update_val_id = 5'd3; update_val_dep = 5'd10;
        update_val = 32'h77;
        is_update_dep = 1'b1; update_dep_id = 5'd8; update_dep = 5'd1;
        qry1_id = 5'd3; #1;
        n_total++;
        if (qry1_has_dep !== 1'b1 || qry1_val !== old3)
            $display("FAIL flush_nobypass: got has=%b val=%h, want 1/%h",
                     qry1_has_dep, qry1_val, old3);
        else n_pass++;
        tick();
        qry2_id = 5'd4; #1;
        n_total++;
        if (qry1_has_dep !== 1'b0 || qry1_val !== old3 || qry2_has_dep !== 1'b0)
            $display("FAIL flush_after: got x3 has=%b val=%h x4 has=%b, want 0/%h/0",
                     qry1_has_dep, qry1_val, qry2_has_dep, old3);
        else n_pass++;
        qry1_id = 5'd8; #1;
        n_total++;
        if (qry1_has_dep !== 1'b0)
            $display("FAIL flush_x8: got has=%b, want 0", qry1_has_dep);
        else n_pass++;
        rdy_in = 1'b0;
        is_update_dep = 1'b1; update_dep_id = 5'd9; update_dep = 5'd5;
        is_update_val = 1'b1; update_val_id = 5'd9; update_val = 32'hBEEF;
        tick();
        qry1_id = 5'd9; #1;
        n_total++;
        if (qry1_has_dep !== 1'b0 || qry1_val !== m_val[9])
            $display("FAIL stall_x9: got has=%b val=%h, want 0/%h",
                     qry1_has_dep, qry1_val, m_val[9]);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0]   ev;
        logic          eh;
        logic [RB-1:0] ed;
        for (int c = 0; c < 400; c++) begin
            rdy_in        = ($urandom_range(0, 9) != 0);
            rob_clear     = ($urandom_range(0, 19) == 0);
            is_update_val = ($urandom_range(0, 1) == 1);
            update_val_id = 5'($urandom_range(0, 7));
            // Mostly commit the current youngest tag so bypass/clear is exercised.
            update_val_dep = ($urandom_range(0, 3) != 0) ? m_dep[update_val_id] : RB'($urandom);
            update_val    = $urandom;
            is_update_dep = ($urandom_range(0, 1) == 1);
            update_dep_id = 5'($urandom_range(0, 7));
            update_dep    = RB'($urandom);
            qry1_id       = 5'($urandom_range(0, 7));
            qry2_id       = ($urandom_range(0, 1) == 1) ? update_val_id : 5'($urandom);
            #1;
            exp_q(qry1_id, ev, eh, ed);
            n_total++;
            if (qry1_val !== ev || qry1_has_dep !== eh || (eh && qry1_dep !== ed))
                $display("FAIL rand_q1 c%0d x%0d: got %h/%b/%0d, want %h/%b/%0d",
                         c, qry1_id, qry1_val, qry1_has_dep, qry1_dep, ev, eh, ed);
            else n_pass++;
            exp_q(qry2_id, ev, eh, ed);
            n_total++;
            if (qry2_val !== ev || qry2_has_dep !== eh || (eh && qry2_dep !== ed))
                $display("FAIL rand_q2 c%0d x%0d: got %h/%b/%0d, want %h/%b/%0d",
                         c, qry2_id, qry2_val, qry2_has_dep, qry2_dep, ev, eh, ed);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        rst_in = 1'b1;
        idle_inputs();
        qry1_id = '0; qry2_id = '0;
        model_clear();
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        test_reset();
        test_rename_commit();
        test_stale_commit();
        test_same_cycle();
        test_x0();
        test_flush_and_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with per-register rename tags; sits directly downstream of the reorder buffer's commit port and beside the decoder.
- Holds 32 x 32-bit values plus, per register, a busy flag and the ROB id of the youngest in-flight producer.
- ROB commits write values; decoder issue writes rename tags.
- Two combinational query ports give the decoder each source operand's value or its ROB dependency, with same-cycle commit bypass.

Parameters:
ROB_SIZE_BIT, 5, width of a ROB id (taken from the shared config define)
REG_NUM, 32, number of architectural registers; index width fixed at 5

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset; asynchronous, active-high
rdy_in  input  1  ready; state frozen when low
rob_clear  input  1  flush from ROB; drop all rename tags
is_update_val  input  1  ROB commit valid
update_val_id  input  5  committed destination register
update_val_dep  input  ROB_SIZE_BIT  ROB id of committing entry
update_val  input  32  committed value
is_update_dep  input  1  rename valid (new instruction issued)
update_dep_id  input  5  renamed destination register
update_dep  input  ROB_SIZE_BIT  ROB id assigned to new producer
qry1_id  input  5  source register 1
qry1_val  output  32  register value (valid when qry1_has_dep=0)
qry1_has_dep  output  1  operand still pending in ROB
qry1_dep  output  ROB_SIZE_BIT  producing ROB id
qry2_id / qry2_val / qry2_has_dep / qry2_dep  same as port 1

Behaviour:
- State: val[0..31], busy[0..31], dep[0..31]. Async reset (rst_in high): all cleared to 0. Query outputs are combinational, so after reset every query returns val 0, has_dep 0, dep 0.
- rdy_in low: no state change. Queries stay live.
- Normal cycle (rdy_in=1, rob_clear=0), all updates on posedge:
  - Commit: if is_update_val and update_val_id!=0, then val[id] <= update_val.
    - If busy[id] and dep[id]==update_val_dep, busy[id] <= 0.
    - Otherwise busy/dep are untouched (stale commit: a younger producer exists).
  - Rename: if is_update_dep and update_dep_id!=0, then busy[id] <= 1 and dep[id] <= update_dep.
  - Simultaneous commit and rename to the same register: the value is written, busy stays 1, and dep takes update_dep. Rename wins over busy-clear.
- Flush (rdy_in=1, rob_clear=1):
  - All busy <= 0.
  - is_update_val and is_update_dep are ignored that cycle, because ROB outputs are meaningless during the clear.
  - val is kept.
- Register x0: never written, never busy. A query of x0 returns val 0, has_dep 0, dep 0.
- Query path (per port, combinational, zero latency):
  - Bypass case: is_update_val && !rob_clear && update_val_id==qry_id!=0 && busy[qry_id] && dep[qry_id]==update_val_dep. Returns qry_val=update_val, has_dep=0.
  - Otherwise: qry_val=val[qry_id], has_dep=busy[qry_id], dep=dep[qry_id].
  - The same-cycle rename is not forwarded to queries. The issuing instruction's sources see the pre-rename mapping (e.g. add x5,x5,x1 depends on the old x5).
- ROB ids wrap modulo 2^ROB_SIZE_BIT. Tag compare is exact equality only.

Decomposition:
- Config.v (shared) holds ROB_SIZE_BIT / ROB_SIZE and a REG_NUM define.
- Single flat module; no sub-module. The two query ports are identical logic, implemented with a generate or a function for the bypass mux.

Test Plan:
1. Reset mid-run (rst_in pulsed asynchronously between edges) -> immediately qry1_id=5 gives val 0, has_dep 0; qry2_id=0 gives val 0, has_dep 0.
2. Rename x5 with dep 3, next cycle query x5 -> has_dep 1, dep 3. Then commit id5/dep3/0x1234 -> same cycle query has_dep 0, val 0x1234; following cycle stored val 0x1234, busy 0.
3. Rename x5 dep 3, then rename x5 dep 7, then commit x5 dep 3 val 0xAA -> val[5]=0xAA but has_dep 1, dep 7, and no bypass on the commit cycle.
4. Same cycle: commit x6 dep 2 val 0x55 (x6 busy with dep 2) plus rename x6 dep 9 -> next cycle val 0x55, has_dep 1, dep 9. Query on that cycle sees bypass 0x55/has_dep 0.
5. Commit and rename to x0 with val 0xFFFF -> x0 stays val 0, has_dep 0.
6. x3,x4 busy. Assert rob_clear with commit x3 val 0x77 and rename x8 dep 1 -> next cycle all has_dep 0, val[3] unchanged, x8 not busy. Separately, rdy_in=0 with rename x9 -> x9 unchanged.
